// File: rtl/hazard_scoreboard_fwd.sv
// ID-stage hazard unit: shadows in-flight register writes for DEPTH stages,
// selects the youngest forwarding stage per source and raises load-use stalls.
module hazard_scoreboard_fwd #(
  parameter  int unsigned REG_AW    = 2,
  parameter  int unsigned DEPTH     = 3,
  parameter  int unsigned LAT_W     = 2,
  parameter  int unsigned ZERO_HARD = 1,
  parameter  int unsigned CNT_W     = 8,
  localparam int unsigned FWD_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              flush,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_vld [1:DEPTH];
  logic [REG_AW-1:0] r_reg [1:DEPTH];
  logic [LAT_W-1:0]  r_lat [1:DEPTH];
  logic [CNT_W-1:0]  r_cnt;

  logic              w_hit_a, w_rdy_a, w_hit_b, w_rdy_b;
  logic [FWD_W-1:0]  w_sel_a, w_sel_b;
  logic              w_zero_a, w_zero_b;
  logic              w_stall;
  logic              w_load;
  logic [LAT_W-1:0]  w_lat_in;

  assign w_zero_a = (ZERO_HARD != 0) && (id_rs == '0);
  assign w_zero_b = (ZERO_HARD != 0) && (id_rt == '0);

  // Youngest (lowest-numbered) matching stage wins; older matches are ignored.
  always_comb begin
    w_hit_a = 1'b0;
    w_rdy_a = 1'b0;
    w_sel_a = '0;
    w_hit_b = 1'b0;
    w_rdy_b = 1'b0;
    w_sel_b = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!w_hit_a && id_use_rs && !w_zero_a && r_vld[k] && (r_reg[k] == id_rs)) begin
        w_hit_a = 1'b1;
        w_rdy_a = k > 32'(r_lat[k]);
        w_sel_a = FWD_W'(k);
      end
      if (!w_hit_b && id_use_rt && !w_zero_b && r_vld[k] && (r_reg[k] == id_rt)) begin
        w_hit_b = 1'b1;
        w_rdy_b = k > 32'(r_lat[k]);
        w_sel_b = FWD_W'(k);
      end
    end
  end

  assign fwd_a   = (w_hit_a && w_rdy_a) ? w_sel_a : '0;
  assign fwd_b   = (w_hit_b && w_rdy_b) ? w_sel_b : '0;
  assign w_stall = id_valid && !flush &&
                   ((w_hit_a && !w_rdy_a) || (w_hit_b && !w_rdy_b));
  assign stall   = w_stall;
  assign w_load  = id_valid && id_wr_en && !w_stall && !flush;

  // Out-of-range latency is clamped so a producer always becomes ready before it leaves.
  assign w_lat_in = (32'(id_lat) >= DEPTH) ? LAT_W'(DEPTH - 1) : id_lat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        r_vld[k] <= 1'b0;
        r_reg[k] <= '0;
        r_lat[k] <= '0;
      end
    end else begin
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_reg[k] <= r_reg[k-1];
        r_lat[k] <= r_lat[k-1];
      end
      r_vld[1] <= w_load;
      r_reg[1] <= w_load ? id_wr_reg : '0;
      r_lat[1] <= w_load ? w_lat_in : '0;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
// Directed bench for hazard_scoreboard_fwd: vector table on the default build,
// plus a deep/narrow-counter build for long stalls and asynchronous reset.
module tb_hazard_scoreboard_fwd;

  logic       clk = 1'b0;
  logic       reset_n, reset_n2;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, flush;
  logic [1:0] id_rs, id_rt, id_wr_reg, id_lat;
  logic [2:0] id_lat2;
  logic [1:0] fwd_a, fwd_b;
  logic       stall;
  logic [7:0] stall_cnt;
  logic [2:0] fwd_a2, fwd_b2;
  logic       stall2;
  logic [1:0] stall_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_fwd dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_lat(id_lat), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard_fwd #(.REG_AW(2), .DEPTH(6), .LAT_W(3), .ZERO_HARD(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n2), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_lat(id_lat2), .flush(flush),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall(stall2), .stall_cnt(stall_cnt2)
  );

  typedef struct {
    logic       v;
    logic [1:0] rs, rt;
    logic       urs, urt, we;
    logic [1:0] wr, lat;
    logic       fl;
    logic [1:0] fa, fb;
    logic       st;
    logic [7:0] cnt;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic v, input logic [1:0] rs, input logic [1:0] rt,
                              input logic urs, input logic urt, input logic we,
                              input logic [1:0] wr, input logic [1:0] lat, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb, input logic st,
                              input logic [7:0] cnt);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.we = we;
    r.wr = wr; r.lat = lat; r.fl = fl; r.fa = fa; r.fb = fb; r.st = st; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_wr_en = 1'b0; id_wr_reg = '0; id_lat = '0; id_lat2 = '0; flush = 1'b0;
  endtask

  initial begin
    //              v  rs rt urs urt we wr lat fl | fa fb st cnt
    vecs[0]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0);  // ALU wr r1
    vecs[1]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0,   2, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0,   3, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 1, 2, 1, 0,   0, 0, 0, 0);  // load wr r2
    vecs[6]  = mk(1, 0, 2, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0);
    vecs[7]  = mk(1, 0, 2, 0, 1, 0, 0, 0, 0,   0, 2, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    vecs[9]  = mk(1, 0, 0, 0, 0, 1, 3, 1, 0,   0, 0, 0, 1);  // load r3
    vecs[10] = mk(1, 0, 0, 0, 0, 1, 3, 0, 0,   0, 0, 0, 1);  // ALU r3
    vecs[11] = mk(1, 3, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 1);  // ALU r1
    vecs[13] = mk(1, 0, 0, 0, 0, 1, 1, 1, 0,   0, 0, 0, 1);  // load r1
    vecs[14] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1);  // older ready ALU not used
    vecs[15] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0,   2, 0, 0, 2);
    vecs[16] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 2);  // wr r0
    vecs[17] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 2);
    vecs[18] = mk(1, 0, 0, 0, 0, 1, 2, 1, 0,   0, 0, 0, 2);  // load r2
    vecs[19] = mk(1, 0, 2, 0, 1, 1, 3, 0, 1,   0, 0, 0, 2);  // flushed load-use
    vecs[20] = mk(1, 3, 2, 1, 1, 0, 0, 0, 0,   0, 2, 0, 2);
    vecs[21] = mk(1, 0, 0, 0, 0, 1, 1, 3, 0,   0, 0, 0, 2);  // illegal lat 3
    vecs[22] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 2);
    vecs[23] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 3);
    vecs[24] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0,   3, 0, 0, 4);
    vecs[25] = mk(1, 0, 0, 0, 0, 1, 2, 1, 0,   0, 0, 0, 4);  // load r2
    vecs[26] = mk(0, 0, 2, 0, 1, 0, 0, 0, 0,   0, 0, 0, 4);  // no valid, no stall
    vecs[27] = mk(0, 0, 2, 0, 1, 0, 0, 0, 0,   0, 2, 0, 4);

    drive_idle();
    reset_n = 1'b0;
    reset_n2 = 1'b0;

    // Reset with random inputs
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      id_valid = 1'b1; id_rs = 2'($urandom); id_rt = 2'($urandom);
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom); id_wr_en = 1'($urandom);
      id_wr_reg = 2'($urandom); id_lat = 2'($urandom); flush = 1'b0;
      @(negedge clk);
      check("rst fwd_a", 32'(fwd_a), 0);
      check("rst fwd_b", 32'(fwd_b), 0);
      check("rst stall", 32'(stall), 0);
      check("rst stall_cnt", 32'(stall_cnt), 0);
    end
    @(posedge clk); #1;
    drive_idle();
    reset_n = 1'b1;
    reset_n2 = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      id_valid = vecs[i].v; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_use_rs = vecs[i].urs; id_use_rt = vecs[i].urt; id_wr_en = vecs[i].we;
      id_wr_reg = vecs[i].wr; id_lat = vecs[i].lat; flush = vecs[i].fl;
      @(negedge clk);
      check($sformatf("v%0d fwd_a", i), 32'(fwd_a), 32'(vecs[i].fa));
      check($sformatf("v%0d fwd_b", i), 32'(fwd_b), 32'(vecs[i].fb));
      check($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].st));
      check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].cnt));
    end

    // Deep build: lat 5 producer gives 5 stalls, 2-bit counter saturates
    drive_idle();
    #1 reset_n2 = 1'b0;
    #1 reset_n2 = 1'b1;
    @(posedge clk); #1;
    id_valid = 1'b1; id_wr_en = 1'b1; id_wr_reg = 2'd1; id_lat2 = 3'd5;
    @(negedge clk);
    check("deep issue stall", 32'(stall2), 0);
    @(posedge clk); #1;
    id_wr_en = 1'b0; id_wr_reg = '0; id_lat2 = '0; id_rs = 2'd1; id_use_rs = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("deep c%0d stall", c), 32'(stall2), (c <= 5) ? 1 : 0);
      check($sformatf("deep c%0d stall_cnt", c), 32'(stall_cnt2), (c - 1 > 3) ? 3 : 32'(c - 1));
      check($sformatf("deep c%0d fwd_a", c), 32'(fwd_a2), (c == 6) ? 6 : 0);
      @(posedge clk); #1;
    end

    // Reset asserted in the middle of a stall
    id_use_rs = 1'b0; id_wr_en = 1'b1; id_wr_reg = 2'd1; id_lat2 = 3'd5;
    @(posedge clk); #1;
    id_wr_en = 1'b0; id_wr_reg = '0; id_lat2 = '0; id_use_rs = 1'b1;
    @(negedge clk);
    check("mid stall before rst", 32'(stall2), 1);
    #2 reset_n2 = 1'b0;
    #1;
    check("async rst stall", 32'(stall2), 0);
    check("async rst stall_cnt", 32'(stall_cnt2), 0);
    check("async rst fwd_a", 32'(fwd_a2), 0);
    @(posedge clk); #1;
    reset_n2 = 1'b1;
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
